// File: rtl/cmult_word_adapter.sv
// Packs four n-bit operand words into one 4n-bit multiplier request and streams each 2n-bit result out as two words (cr, then cc).
// Request valid one cycle after the 4th word, first result word one cycle after capture; a stalled side holds its state with rdy low.
module cmult_word_adapter #(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_val,
  output logic           in_rdy,
  input  logic [n-1:0]   in_msg,
  output logic           mul_val,
  input  logic           mul_rdy,
  output logic [4*n-1:0] mul_msg,
  input  logic           res_val,
  output logic           res_rdy,
  input  logic [2*n-1:0] res_msg,
  output logic           out_val,
  input  logic           out_rdy,
  output logic [n-1:0]   out_msg
);

  typedef enum logic {COLLECT, ISSUE} req_state_t;
  typedef enum logic [1:0] {IDLE, HI, LO} rsp_state_t;

  req_state_t     req_state;
  rsp_state_t     rsp_state;
  logic [1:0]     cnt;
  logic [n-1:0]   slot [4];
  logic [2*n-1:0] res_q;
  logic           in_hs;
  logic           res_hs;

  assign in_hs  = in_val && in_rdy;
  assign res_hs = res_val && res_rdy;

  // Request side: rdy/val are registered so nothing from in_* reaches mul_* combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_state <= COLLECT;
      cnt       <= 2'd0;
      in_rdy    <= 1'b0;
      mul_val   <= 1'b0;
    end else begin
      case (req_state)
        COLLECT: begin
          in_rdy <= 1'b1;
          if (in_hs) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              req_state <= ISSUE;
              in_rdy    <= 1'b0;
              mul_val   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mul_rdy) begin
            req_state <= COLLECT;
            mul_val   <= 1'b0;
            in_rdy    <= 1'b1;
          end
        end
        default: req_state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) slot[cnt] <= in_msg;
  end

  assign mul_msg = {slot[0], slot[1], slot[2], slot[3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_state <= IDLE;
      res_rdy   <= 1'b0;
      out_val   <= 1'b0;
    end else begin
      case (rsp_state)
        IDLE: begin
          res_rdy <= 1'b1;
          if (res_hs) begin
            rsp_state <= HI;
            res_rdy   <= 1'b0;
            out_val   <= 1'b1;
          end
        end
        HI: begin
          if (out_rdy) rsp_state <= LO;
        end
        LO: begin
          if (out_rdy) begin
            rsp_state <= IDLE;
            out_val   <= 1'b0;
            res_rdy   <= 1'b1;
          end
        end
        default: rsp_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res_hs) res_q <= res_msg;
  end

  assign out_msg = (rsp_state == LO) ? res_q[n-1:0] : res_q[2*n-1:n];

endmodule

// File: doc/cmult_word_adapter.md
# cmult_word_adapter

Word-serial front end for the fixed-point complex multiplier harness. Collects four n-bit operand words (ar, ac, br, bc) from a narrow val/rdy stream and packs them into the 4n-bit multiplier request. Splits each 2n-bit result into two n-bit words (cr, then cc) on a narrow val/rdy output stream. Sits between the chip's word-wide I/O (SPI/router side) and the multiplier harness; the request and response paths are fully independent.

## Interface

- n, 32, operand/result word width in bits; the adapter does no arithmetic, so the fractional width d is not a parameter.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; state clears immediately on assertion; release is synchronous to clk.
- in_val  in  1  input word valid.
- in_rdy  out  1  adapter can accept an input word.
- in_msg  in  n  input word.
- mul_val  out  1  packed request valid (to multiplier recv_val).
- mul_rdy  in  1  multiplier ready (from multiplier recv_rdy).
- mul_msg  out  4n  packed request {ar, ac, br, bc}; ar occupies [4n-1:3n], bc occupies [n-1:0].
- res_val  in  1  multiplier result valid (from send_val).
- res_rdy  out  1  adapter can accept a result (to send_rdy).
- res_msg  in  2n  result {cr, cc}; cr occupies [2n-1:n].
- out_val  out  1  output word valid.
- out_rdy  in  1  downstream ready.
- out_msg  out  n  output word.

## Operation

- A handshake occurs on any port pair in a cycle where val && rdy are both high at the rising edge.
- Request FSM has two states, COLLECT and ISSUE, plus a 2-bit word counter cnt.
  - COLLECT: in_rdy=1, mul_val=0. Each in handshake writes in_msg into slot cnt and increments cnt.
  - Slot 0 maps to mul_msg[4n-1:3n] (ar), slot 1 to ac, slot 2 to br, slot 3 to [n-1:0] (bc).
  - The handshake with cnt==3 moves the FSM to ISSUE and wraps cnt to 0.
  - ISSUE: in_rdy=0, mul_val=1, mul_msg held stable. A mul handshake returns the FSM to COLLECT.
- Response FSM has three states: IDLE, HI, LO.
  - IDLE: res_rdy=1, out_val=0. A res handshake captures res_msg into a 2n-bit register and moves to HI.
  - HI: out_val=1, out_msg=cr. An out handshake moves to LO.
  - LO: out_val=1, out_msg=cc. An out handshake moves to IDLE.
  - In HI and LO, res_rdy=0.
- The two FSMs run concurrently. A request may be collected or issued while a previous result is being streamed out.
- Once mul_val or out_val is asserted, its message is stable until the handshake completes. Deassertion before the handshake never occurs.
- In-flight reset (reset low at any time):
  - The partial word collection is discarded: cnt=0, FSMs return to COLLECT and IDLE.
  - The captured result is discarded.
  - No partial request is ever issued.
- Data registers need no reset. Their contents are don't-care while the corresponding val is low.

## Timing

- Reset values (while reset is low and in the first cycle after release): in_rdy=0, mul_val=0, res_rdy=0, out_val=0. in_rdy and res_rdy rise to 1 on the first clk edge after release. mul_msg and out_msg are don't-care.
- Request latency: mul_val rises in the cycle after the 4th word handshake. There is no combinational path from in_* to mul_*.
- Response latency: out_val rises (with cr) in the cycle after the res handshake. There is no combinational path from res_* to out_*.
- All outputs are driven from registers or state decode only. There is no combinational val→rdy or rdy→val path.
- Peak throughput: one request per 5 cycles (4 collect + 1 issue) and one result per 3 cycles (1 capture + 2 words).
- With mul_rdy low, ISSUE holds indefinitely and in_rdy stays 0, so backpressure propagates to the input.
- With out_rdy low, HI or LO holds indefinitely and res_rdy stays 0, so backpressure propagates to the multiplier.

## Test plan

- **Basic pack.** Send 0x00010000, 0x00020000, 0x00030000, 0x00040000 with mul_rdy=1.
  - Required: mul_val is high for exactly 1 cycle, one cycle after the 4th word.
  - Required: mul_msg = 0x00010000_00020000_00030000_00040000.
- **Basic unpack.** Present res_msg = 0xFFFB0000_000A0000 with out_rdy=1.
  - Required: out words 0xFFFB0000 then 0x000A0000 on consecutive cycles.
  - Required: res_rdy is low for 2 cycles, then high.
- **Request backpressure.** Hold mul_rdy=0 for 10 cycles after collection.
  - Required: mul_val stays 1 and mul_msg is stable; in_rdy stays 0 and no extra words are consumed.
  - Release mul_rdy. Required: in_rdy returns to 1 the next cycle and the next four words pack correctly.
- **Output backpressure with overlap.** Toggle out_rdy randomly (~30% high) while feeding 8 back-to-back requests through a reference multiplier model (Q16.16).
  - Required: every cr/cc pair matches the model in order, with no drops or duplicates.
- **Reset mid-collect.** Accept 2 words, pull reset low for 1 cycle, then send 4 fresh words.
  - Required: the first mul_msg contains only the 4 fresh words.
  - Required: all val/rdy outputs read 0 while reset is low.
- **Reset mid-output.** Assert reset while in HI.
  - Required: out_val drops immediately (asynchronously).
  - Required: the cc word of that result is never emitted after release.
